sonic_echo_responder: RTL and testbench
=======================================

Name: sonic_echo_responder

Overview:
- Synthesizable model of the ultrasonic ranging sensor: the responder side of the Trig/Echo protocol.
- Accepts the 10 us trigger pulse and returns an Echo pulse whose width encodes a programmed distance at 58 us/cm.
- Used for hardware-in-loop and simulation checks of the kart ranging path without a physical sensor attached.
- Timing is in 100 MHz clock cycles. All durations are exact cycle counts.

Parameters:
- CLK_PER_US, 100, clock cycles per microsecond.
- MIN_TRIG_US, 10, minimum trig high width accepted.
- BURST_US, 200, delay from accepted trig fall to echo rise (emulates the 8-pulse burst).
- US_PER_CM, 58, echo microseconds per centimetre.
- MIN_CM, 2, lower distance clamp.
- MAX_CM, 400, largest in-range distance.
- TIMEOUT_US, 38000, echo width for no-object or out-of-range.
- HOLDOFF_US, 1000, dead time after echo fall before a new trigger is accepted.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- trig  in  1  trigger from the ranging master; asynchronous, so the block synchronizes it internally.
- distance_cm  in  9  target distance in cm; sampled once per accepted trigger.
- obj_present  in  1  0 forces the timeout echo; sampled with distance_cm.
- echo  out  1  echo pulse to the master.
- busy  out  1  high from trigger acceptance through the end of holdoff.
- short_trig  out  1  one-cycle pulse when a trigger is rejected for being too short.

Behaviour:
- Reset: on a clk edge with rst=1, echo=0, busy=0 and short_trig=0. State goes to IDLE and all counters clear. Reset mid-echo drops echo at that edge.
- trig passes through a 2-flop synchronizer, giving trig_s. A third register holds the previous value for edge detection.
- There is one cycle counter (cyc). It clears on every state entry. An internal us counter increments when cyc reaches CLK_PER_US-1, and cyc wraps at that point.
- IDLE: on a trig_s rising edge, go to TRIG_HI. A trig_s that is already high on entry to IDLE is not a rising edge and is ignored.
- TRIG_HI: count clk cycles while trig_s=1. The count saturates at MIN_TRIG_US*CLK_PER_US, so a stuck-high trig never wraps and never fires.
- TRIG_HI, falling edge (detect cycle D):
  - If count >= MIN_TRIG_US*CLK_PER_US: latch the echo width W, set busy=1 from D+1, and go to BURST.
  - Otherwise: pulse short_trig for 1 cycle (D+1) and return to IDLE.
- Width W (in us) is computed at D:
  - obj_present=0 or distance_cm>MAX_CM: W = TIMEOUT_US.
  - distance_cm<MIN_CM: W = MIN_CM*US_PER_CM.
  - Otherwise: W = distance_cm*US_PER_CM.
  - W is 16-bit unsigned. The largest value is 38000.
- Latched values: later changes to distance_cm or obj_present do not affect a transaction in progress.
- BURST: lasts exactly BURST_US*CLK_PER_US cycles. The first cycle with echo=1 is D+1+BURST_US*CLK_PER_US.
- ECHO: echo=1 for exactly W*CLK_PER_US consecutive cycles, then 0.
- HOLDOFF: lasts HOLDOFF_US*CLK_PER_US cycles with echo=0. busy falls on the cycle IDLE is entered.
- Any trig activity during BURST, ECHO or HOLDOFF is ignored and produces no short_trig.
- Simultaneous events: rst has priority over everything. short_trig and echo are never high together.

Test Plan:
- Nominal: distance_cm=100, obj_present=1, trig high 10 us (1000 cycles) -> echo rises at D+1+20000, echo high exactly 580000 cycles, busy high D+1 through echo fall + 100000 cycles.
- Short trigger: trig high 999 cycles -> short_trig=1 for exactly 1 cycle at D+1, echo stays 0, busy stays 0. A following 1000-cycle trig is accepted normally.
- Timeout: obj_present=0, distance_cm=100 -> echo width 3800000 cycles. Repeat with obj_present=1, distance_cm=450 -> same width.
- Clamp and latch: distance_cm=1 -> width 11600 cycles. Separately, distance_cm=50 at D, then changed to 300 mid-echo -> width stays 290000 cycles.
- Retrigger: 10 us trig pulses during BURST, ECHO and HOLDOFF -> no effect on echo timing, no short_trig. Trig held high across the end of holdoff -> not accepted until it falls and rises again.
- Reset mid-operation: rst=1 for 1 cycle halfway through the echo -> echo=0 and busy=0 at that edge. A new 10 us trig afterwards gives a correct nominal response.

Source files
------------

// File: rtl/sonic_echo_responder_if.sv
// Trig/Echo bus between a ranging master and the echo responder.
// The master drives the trigger and the programmed target; the responder
// drives echo and its status flags.
interface sonic_echo_responder_if;
    logic       trig;
    logic [8:0] distance_cm;
    logic       obj_present;
    logic       echo;
    logic       busy;
    logic       short_trig;

    modport master (
        output trig, distance_cm, obj_present,
        input  echo, busy, short_trig
    );

    modport slave (
        input  trig, distance_cm, obj_present,
        output echo, busy, short_trig
    );
endinterface

// File: rtl/sonic_echo_responder.sv
// Ultrasonic ranging sensor responder (Trig/Echo protocol).
// Accepts a trigger of at least MIN_TRIG_US, waits BURST_US, then returns
// an echo whose width encodes the programmed distance at US_PER_CM.
// All timing is built from one cycle counter (cyc) and one microsecond
// counter (us), both cleared on every state change.
module sonic_echo_responder #(
    parameter int CLK_PER_US  = 100,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    sonic_echo_responder_if.slave  bus
);

    localparam int CYC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(CLK_PER_US - 1);
    localparam logic [15:0]      TRIG_SAT   = 16'(MIN_TRIG_US);
    localparam logic [15:0]      BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0]      HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]      W_TIMEOUT  = 16'(TIMEOUT_US);
    localparam logic [15:0]      W_MIN      = 16'(MIN_CM * US_PER_CM);
    localparam logic [8:0]       D_MAX      = 9'(MAX_CM);
    localparam logic [8:0]       D_MIN      = 9'(MIN_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             trig_m;
    logic             trig_s;
    logic             trig_q;
    logic             trig_rise;
    logic             trig_fall;

    logic [CYC_W-1:0] cyc;
    logic [15:0]      us;
    logic             us_tick;
    logic             trig_long;

    logic [15:0]      width;
    logic [15:0]      w_calc;
    logic             latch_w;
    logic             short_nxt;

    assign trig_rise = trig_s & ~trig_q;
    assign trig_fall = ~trig_s & trig_q;
    assign us_tick   = (cyc == CYC_LAST);

    // Trigger high time reached the minimum: either saturated, or this is
    // the last cycle of the final microsecond (the edge cycle itself counts
    // as the first high cycle, so only MIN*CLK-1 cycles are seen in TRIG_HI).
    assign trig_long = (us == TRIG_SAT) ||
                       ((us == TRIG_SAT - 16'd1) && us_tick);

    // Two-flop synchronizer on trig plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            trig_m <= bus.trig;
            trig_s <= trig_m;
            trig_q <= trig_s;
        end
    end

    // Echo width in microseconds for the currently presented target
    always_comb begin
        w_calc = 16'(bus.distance_cm) * 16'(US_PER_CM);
        if (!bus.obj_present || (bus.distance_cm > D_MAX)) begin
            w_calc = W_TIMEOUT;
        end else if (bus.distance_cm < D_MIN) begin
            w_calc = W_MIN;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; also flags width latch and short-trigger pulse
    always_comb begin
        state_nxt = state;
        latch_w   = 1'b0;
        short_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (trig_rise) begin
                    state_nxt = TRIG_HI;
                end
            end
            TRIG_HI: begin
                if (trig_fall) begin
                    if (trig_long) begin
                        state_nxt = BURST;
                        latch_w   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        short_nxt = 1'b1;
                    end
                end
            end
            BURST: begin
                if (us_tick && (us == BURST_LAST)) begin
                    state_nxt = ECHO;
                end
            end
            ECHO: begin
                if (us_tick && (us == width - 16'd1)) begin
                    state_nxt = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (us_tick && (us == HOLD_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Cycle / microsecond counters; clear on state change, saturate in
    // TRIG_HI so a stuck-high trigger never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc <= '0;
            us  <= '0;
        end else if ((state_nxt != state) || (state == IDLE)) begin
            cyc <= '0;
            us  <= '0;
        end else if ((state == TRIG_HI) && (us == TRIG_SAT)) begin
            cyc <= cyc;
            us  <= us;
        end else if (us_tick) begin
            cyc <= '0;
            us  <= us + 16'd1;
        end else begin
            cyc <= cyc + CYC_W'(1);
        end
    end

    // Width is captured once per accepted trigger and held for the echo
    always_ff @(posedge clk) begin
        if (rst) begin
            width <= '0;
        end else if (latch_w) begin
            width <= w_calc;
        end
    end

    // Registered outputs, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.echo       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.short_trig <= 1'b0;
        end else begin
            bus.echo       <= (state_nxt == ECHO);
            bus.busy       <= (state_nxt == BURST) || (state_nxt == ECHO) ||
                              (state_nxt == HOLDOFF);
            bus.short_trig <= short_nxt;
        end
    end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Self-checking bench for sonic_echo_responder with scaled-down timing.
// Stimulus is a per-cycle table of trig / distance / obj_present / rst;
// expected edge times of echo, busy and short_trig are derived from the
// trigger pulses with plain arithmetic and compared to observed edges.
module tb_sonic_echo_responder;

    localparam int CLK_PER_US  = 2;
    localparam int MIN_TRIG_US = 3;
    localparam int BURST_US    = 5;
    localparam int US_PER_CM   = 2;
    localparam int MIN_CM      = 2;
    localparam int MAX_CM      = 40;
    localparam int TIMEOUT_US  = 100;
    localparam int HOLDOFF_US  = 7;
    localparam int MIN_TRIG    = MIN_TRIG_US * CLK_PER_US;
    localparam int NCYC        = 16000;

    logic clk;
    logic rst;
    sonic_echo_responder_if ifc ();

    sonic_echo_responder #(
        .CLK_PER_US (CLK_PER_US),
        .MIN_TRIG_US(MIN_TRIG_US),
        .BURST_US   (BURST_US),
        .US_PER_CM  (US_PER_CM),
        .MIN_CM     (MIN_CM),
        .MAX_CM     (MAX_CM),
        .TIMEOUT_US (TIMEOUT_US),
        .HOLDOFF_US (HOLDOFF_US)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit         trig_a [NCYC];
    bit         rst_a  [NCYC];
    logic [8:0] dist_a [NCYC];
    bit         obj_a  [NCYC];

    int exp_er[$], exp_ef[$], exp_br[$], exp_bf[$], exp_sr[$], exp_sf[$];
    int obs_er[$], obs_ef[$], obs_br[$], obs_bf[$], obs_sr[$], obs_sf[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 1'b0;
    int free_at = 0;
    int cursor  = 5;
    bit p_echo = 1'b0, p_busy = 1'b0, p_short = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int width_us(input int d, input bit o);
        if (!o || d > MAX_CM) return TIMEOUT_US;
        if (d < MIN_CM) return MIN_CM * US_PER_CM;
        return d * US_PER_CM;
    endfunction

    // Place a trig pulse and predict its outcome. The synchronized rise is
    // two cycles after the first high cycle; it only counts if the responder
    // is idle by then (otherwise busy, or held high across idle entry).
    task automatic put_pulse(input int p, input int len);
        int n, d, w, e;
        for (int i = 0; i < len; i++) trig_a[p + i] = 1'b1;
        cursor = p + len + 1;
        n = p + 2;
        if (n < free_at) return;
        d = n + len;
        if (len >= MIN_TRIG) begin
            w = width_us(int'(dist_a[d]), obj_a[d]);
            e = d + 1 + (BURST_US + w) * CLK_PER_US;
            exp_br.push_back(d + 1);
            exp_er.push_back(d + 1 + BURST_US * CLK_PER_US);
            exp_ef.push_back(e);
            exp_bf.push_back(e + HOLDOFF_US * CLK_PER_US);
            free_at = e + HOLDOFF_US * CLK_PER_US;
        end else begin
            exp_sr.push_back(d + 1);
            exp_sf.push_back(d + 2);
            free_at = d + 1;
        end
    endtask

    task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
        int n;
        chk({tag, "_count"}, got.size(), exp.size());
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) chk(tag, got[i], exp[i]);
    endtask

    // Edge monitor: timestamps every output transition in bench cycles
    always @(negedge clk) begin
        if (run) begin
            if (ifc.echo && !p_echo)        obs_er.push_back(cyc);
            if (!ifc.echo && p_echo)        obs_ef.push_back(cyc);
            if (ifc.busy && !p_busy)        obs_br.push_back(cyc);
            if (!ifc.busy && p_busy)        obs_bf.push_back(cyc);
            if (ifc.short_trig && !p_short) obs_sr.push_back(cyc);
            if (!ifc.short_trig && p_short) obs_sf.push_back(cyc);
            if (ifc.short_trig) chk("short_with_echo", int'(ifc.echo), 0);
            p_echo  = ifc.echo;
            p_busy  = ifc.busy;
            p_short = ifc.short_trig;
        end
    end

    initial begin
        int k, seg, sel, p, len, n, d, w, r, er;
        logic [8:0] dv;
        bit ov;

        // Target changes every few cycles so latching is exercised constantly
        k = 0;
        while (k < NCYC) begin
            dv  = 9'($urandom_range(0, 50));
            ov  = ($urandom_range(0, 4) != 0);
            seg = $urandom_range(1, 25);
            for (int i = 0; i < seg && k < NCYC; i++) begin
                dist_a[k] = dv;
                obj_a[k]  = ov;
                k++;
            end
        end

        // Nominal first transaction, then random pulses
        put_pulse(cursor, MIN_TRIG);
        while (cursor < NCYC - 1200) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                p   = cursor + $urandom_range(0, 6);
                len = $urandom_range(1, MIN_TRIG + 3);
            end else if (sel == 3 && free_at - 6 >= cursor) begin
                p   = free_at - 2 - $urandom_range(1, 3);
                len = free_at - p - 1 + $urandom_range(0, 3);
            end else begin
                p = ((cursor > free_at - 2) ? cursor : free_at - 2) + $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0:       len = MIN_TRIG - 1;
                    1:       len = MIN_TRIG;
                    default: len = $urandom_range(1, MIN_TRIG + 4);
                endcase
            end
            put_pulse(p, len);
        end

        // Directed: reset halfway through an echo, then a nominal retrigger
        p = ((cursor > free_at - 2) ? cursor : free_at - 2) + 2;
        for (int i = p; i < NCYC; i++) begin
            dist_a[i] = 9'd20;
            obj_a[i]  = 1'b1;
        end
        for (int i = 0; i < MIN_TRIG; i++) trig_a[p + i] = 1'b1;
        n  = p + 2;
        d  = n + MIN_TRIG;
        w  = width_us(20, 1'b1);
        er = d + 1 + BURST_US * CLK_PER_US;
        r  = er + (w * CLK_PER_US) / 2;
        rst_a[r] = 1'b1;
        exp_br.push_back(d + 1);
        exp_er.push_back(er);
        exp_ef.push_back(r + 1);
        exp_bf.push_back(r + 1);
        free_at = r + 1;
        cursor  = r + 5;
        put_pulse(cursor, MIN_TRIG);

        // Reset state
        rst = 1'b1;
        ifc.trig = 1'b0;
        ifc.distance_cm = '0;
        ifc.obj_present = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_echo", int'(ifc.echo), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_short", int'(ifc.short_trig), 0);

        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
            run = 1'b1;
            rst = rst_a[i];
            ifc.trig = trig_a[i];
            ifc.distance_cm = dist_a[i];
            ifc.obj_present = obj_a[i];
        end
        @(negedge clk);
        run = 1'b0;

        cmp_q("echo_rise", obs_er, exp_er);
        cmp_q("echo_fall", obs_ef, exp_ef);
        cmp_q("busy_rise", obs_br, exp_br);
        cmp_q("busy_fall", obs_bf, exp_bf);
        cmp_q("short_rise", obs_sr, exp_sr);
        cmp_q("short_fall", obs_sf, exp_sf);
        chk("end_echo", int'(ifc.echo), 0);
        chk("end_busy", int'(ifc.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
